// File: rtl/fb_write_if.sv
// Byte-in / pixel-write bundle between the SPI receiver, the framebuffer
// write controller and the dual-buffer pixel RAM.
interface fb_write_if #(
   parameter int ADDR_WIDTH = 17
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  vblank;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [5:0]            wr_data;
   logic                  wr_buf;
   logic                  rd_buf;
   logic                  swap_pending;
   logic                  frame_done;
   logic                  err_drop;

   modport master (
      output rx_valid, rx_data, vblank,
      input  wr_en, wr_addr, wr_data, wr_buf, rd_buf,
             swap_pending, frame_done, err_drop
   );

   modport slave (
      input  rx_valid, rx_data, vblank,
      output wr_en, wr_addr, wr_data, wr_buf, rd_buf,
             swap_pending, frame_done, err_drop
   );
endinterface

// File: rtl/fb_write_ctrl.sv
// Framebuffer write controller: decodes SPI bytes into back-buffer pixel
// writes and defers front/back buffer swaps until vertical blanking.
module fb_write_ctrl #(
   parameter  int RES_X      = 320,
   parameter  int RES_Y      = 240,
   localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y)
) (
   input  logic       clk,
   input  logic       rst_n,
   fb_write_if.slave  bus
);

   localparam int                    PIXELS     = RES_X * RES_Y;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(PIXELS);

   typedef enum logic [1:0] {
      ST_WRITE,
      ST_FULL,
      ST_SWAP_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [5:0]            wr_data_q, wr_data_d;
   logic                  frame_done_q, frame_done_d;
   logic                  rd_buf_q, rd_buf_d;
   logic                  err_drop_q, err_drop_d;

   logic is_pixel;
   logic is_align;
   logic is_swap;

   assign is_pixel = bus.rx_valid && !bus.rx_data[7];
   assign is_align = bus.rx_valid && (bus.rx_data == 8'h80);
   assign is_swap  = bus.rx_valid && (bus.rx_data == 8'h81);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WRITE;
         count_q      <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         rd_buf_q     <= 1'b0;
         err_drop_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         rd_buf_q     <= rd_buf_d;
         err_drop_q   <= err_drop_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      rd_buf_d     = rd_buf_q;
      err_drop_d   = err_drop_q;

      unique case (state_q)
         ST_WRITE: begin
            if (is_pixel) begin
               wr_en_d   = 1'b1;
               wr_addr_d = count_q;
               wr_data_d = bus.rx_data[5:0];
               if (count_q == LAST_ADDR) begin
                  frame_done_d = 1'b1;
                  count_d      = FULL_COUNT;
                  state_d      = ST_FULL;
               end else begin
                  count_d = count_q + ADDR_WIDTH'(1);
               end
            end else if (is_align) begin
               count_d    = '0;
               err_drop_d = 1'b0;
            end else if (is_swap) begin
               state_d = ST_SWAP_WAIT;
            end
         end

         ST_FULL: begin
            if (is_pixel) begin
               err_drop_d = 1'b1;
            end else if (is_align) begin
               count_d    = '0;
               err_drop_d = 1'b0;
               state_d    = ST_WRITE;
            end else if (is_swap) begin
               state_d = ST_SWAP_WAIT;
            end
         end

         ST_SWAP_WAIT: begin
            // The buffer about to become front must stay untouched, so pixels are dropped here.
            if (is_pixel) begin
               err_drop_d = 1'b1;
            end else if (is_align) begin
               count_d    = '0;
               err_drop_d = 1'b0;
            end
            if (bus.vblank) begin
               rd_buf_d = !rd_buf_q;
               count_d  = '0;
               state_d  = ST_WRITE;
            end
         end

         default: begin
            state_d = ST_WRITE;
         end
      endcase
   end

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.rd_buf       = rd_buf_q;
   assign bus.wr_buf       = !rd_buf_q;
   assign bus.err_drop     = err_drop_q;
   assign bus.swap_pending = (state_q == ST_SWAP_WAIT);

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Randomised scoreboard bench for fb_write_ctrl against a frame-level model.
module tb_fb_write_ctrl;

   localparam int ADDR_W = 17;
   localparam int PIXELS = 320 * 240;

   logic clk;
   logic rst_n;

   fb_write_if #(.ADDR_WIDTH(ADDR_W)) bus ();

   fb_write_ctrl #(.RES_X(320), .RES_Y(240)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int         addr;
      logic [5:0] data;
      logic       buf_idx;
      logic       last;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   int errors = 0;
   int checks = 0;

   int m_count;
   bit m_pending;
   bit m_rd;
   bit m_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame-level model: a pixel lands at the next free address unless the frame is full or a swap waits.
   task automatic model_cycle(input logic v, input logic [7:0] d, input logic vb);
      bit pixel = v && !d[7];
      bit align = v && (d == 8'h80);
      bit swap  = v && (d == 8'h81);
      if (m_pending) begin
         if (pixel) m_err = 1;
         if (align) begin m_count = 0; m_err = 0; end
         if (vb) begin m_rd = !m_rd; m_count = 0; m_pending = 0; end
      end else begin
         if (pixel) begin
            if (m_count < PIXELS) begin
               exp_q.push_back('{m_count, d[5:0], !m_rd, (m_count == PIXELS - 1)});
               m_count++;
            end else begin
               m_err = 1;
            end
         end
         if (align) begin m_count = 0; m_err = 0; end
         if (swap) m_pending = 1;
      end
   endtask

   task automatic model_reset();
      m_count   = 0;
      m_pending = 0;
      m_rd      = 0;
      m_err     = 0;
      exp_q.delete();
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
      model_cycle(v, d, bus.vblank);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic check_state(input string name);
      checks++;
      if (bus.rd_buf !== m_rd || bus.wr_buf !== !m_rd ||
          bus.swap_pending !== m_pending || bus.err_drop !== m_err) begin
         errors++;
         $display("[TB] FAIL %s: got rd=%b wr=%b pend=%b err=%b, required rd=%b wr=%b pend=%b err=%b",
                  name, bus.rd_buf, bus.wr_buf, bus.swap_pending, bus.err_drop,
                  m_rd, !m_rd, m_pending, m_err);
      end
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== 6'd0 ||
          bus.frame_done !== 1'b0 || bus.rd_buf !== 1'b0 || bus.wr_buf !== 1'b1 ||
          bus.swap_pending !== 1'b0 || bus.err_drop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s: got en=%b addr=%0d data=%h fd=%b rd=%b wr=%b pend=%b err=%b, required all 0 except wr=1",
                  name, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done,
                  bus.rd_buf, bus.wr_buf, bus.swap_pending, bus.err_drop);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                        bus.wr_addr, bus.wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.wr_addr !== mon_e.addr[ADDR_W-1:0] || bus.wr_data !== mon_e.data ||
                   bus.wr_buf !== mon_e.buf_idx || bus.frame_done !== mon_e.last) begin
                  errors++;
                  $display("[TB] FAIL write: got addr=%0d data=%h buf=%b fd=%b, required addr=%0d data=%h buf=%b fd=%b",
                           bus.wr_addr, bus.wr_data, bus.wr_buf, bus.frame_done,
                           mon_e.addr, mon_e.data, mon_e.buf_idx, mon_e.last);
               end
            end
         end else if (bus.frame_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_done_alone: got frame_done=1 wr_en=0, required frame_done=0");
         end
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.vblank   = 1'b0;
      model_reset();
      #2;
      check_reset("reset_values");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_state("after_release");

      step(1, 8'h1B);
      step(1, 8'h1B);
      step(1, 8'h3F);
      check_state("three_pixels");

      step(1, 8'h15);
      step(1, 8'h2C);
      step(1, 8'h80);
      step(1, 8'h2A);
      check_state("align_then_pixel");

      step(1, 8'h81);
      check_state("swap_pending_no_vblank");
      step(1, 8'h01);
      check_state("pixel_dropped_in_swap_wait");
      bus.vblank = 1'b1;
      step(0, 8'h00);
      check_state("swap_on_vblank");
      bus.vblank = 1'b0;
      step(1, 8'h05);
      check_state("pixel_after_swap");

      bus.vblank = 1'b1;
      step(1, 8'h81);
      check_state("swap_with_vblank_high");
      step(1, 8'h81);
      check_state("second_swap_ignored");
      step(0, 8'h00);
      step(0, 8'h00);
      check_state("single_toggle");
      bus.vblank = 1'b0;

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         bus.vblank = ($urandom_range(0, 4) == 0);
         if (r <= 5)      step(1, {1'b0, 7'($urandom_range(0, 127))});
         else if (r == 6) step(1, 8'h80);
         else if (r == 7) step(1, 8'h81);
         else if (r == 8) begin b = 8'($urandom_range(8'h82, 8'hFF)); step(1, b); end
         else             step(0, 8'h00);
         check_state("random");
      end

      bus.vblank = 1'b1;
      step(0, 8'h00);
      step(0, 8'h00);
      bus.vblank = 1'b0;
      step(1, 8'h80);
      check_state("pre_fill_align");
      for (int i = 0; i < PIXELS; i++) begin
         step(1, {2'b00, 6'($urandom_range(0, 63))});
      end
      checks++;
      if (bus.frame_done !== 1'b1 || bus.wr_addr !== 17'd76799) begin
         errors++;
         $display("[TB] FAIL frame_done_last: got fd=%b addr=%0d, required fd=1 addr=76799",
                  bus.frame_done, bus.wr_addr);
      end
      step(1, 8'h11);
      check_state("overflow_pixel_dropped");
      step(1, 8'h80);
      check_state("align_clears_err");
      step(1, 8'h22);
      check_state("pixel_after_full_align");

      step(1, 8'h07);
      step(1, 8'h08);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("reset_mid_write");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 8'h3C);
      check_state("pixel_after_reset");

      step(0, 8'h00);
      step(0, 8'h00);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Framebuffer write controller for the SPI-fed VGA display path. It sits between the SPI byte receiver and the dual-buffer pixel RAM. It decodes each received byte as a pixel or a control command, and generates write strobes and addresses into the back buffer. It also schedules front/back buffer swaps so they only take effect during vertical blanking.

## Interface
Parameters:
- RES_X, 320, horizontal resolution in pixels
- RES_Y, 240, vertical resolution in pixels
- ADDR_WIDTH, $clog2(RES_X*RES_Y) (17 at defaults), pixel address width; derived, not overridden

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; one clock, asynchronous, active-low
- rx_valid  in  1  one-cycle pulse, byte received; already in clk domain
- rx_data  in  8  received byte, valid with rx_valid
- vblank  in  1  level, high during VGA vertical blanking
- wr_en  out  1  one-cycle write strobe to pixel RAM
- wr_addr  out  ADDR_WIDTH  pixel address for wr_en
- wr_data  out  6  pixel {R[1:0],G[1:0],B[1:0]}
- wr_buf  out  1  buffer index written (back); always ~rd_buf
- rd_buf  out  1  buffer index displayed (front)
- swap_pending  out  1  high while swap requested but not executed
- frame_done  out  1  one-cycle pulse on write of last pixel
- err_drop  out  1  sticky, a pixel byte was discarded

## Operation
Byte decode, on rx_valid:
- rx_data[7]=0: pixel byte. Color is rx_data[5:0]; rx_data[6] is reserved and ignored.
- 0x80 ALIGN:
  - Pixel counter ← 0.
  - err_drop ← 0.
  - FULL→WRITE.
  - In SWAP_WAIT: state unchanged, swap stays pending.
- 0x81 SWAP:
  - WRITE or FULL → SWAP_WAIT.
  - Ignored in SWAP_WAIT; never queues a second swap.
- Other 0x82–0xFF: ignored, no state or output change.

State machine (reset state WRITE):
- WRITE:
  - A pixel byte issues a write at the counter, then the counter increments.
  - Writing address RES_X*RES_Y-1 pulses frame_done and moves to FULL; the counter holds at RES_X*RES_Y.
- FULL:
  - Pixel bytes are dropped and err_drop ← 1.
  - Exits on ALIGN (→WRITE) or SWAP (→SWAP_WAIT).
- SWAP_WAIT:
  - swap_pending=1.
  - Pixel bytes are dropped and err_drop ← 1, so the buffer about to become front is never modified.
  - In the first cycle with vblank=1, the swap executes:
    - rd_buf and wr_buf toggle.
    - Counter ← 0.
    - State → WRITE.
  - If vblank is already high when SWAP arrives, the swap executes in the following cycle.

Counter and width rules:
- The counter is ADDR_WIDTH bits and never wraps past RES_X*RES_Y.
- The first pixel after ALIGN or a swap goes to address 0; there is no skipped or delayed first byte.

## Timing
- Reset (rst_n low), asynchronous, all outputs immediately:
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0.
  - rd_buf=0, wr_buf=1.
  - swap_pending=0, err_drop=0.
  - Counter=0, state WRITE.
  - An in-flight wr_en is cancelled.
- Pixel latency: rx_valid in cycle N → wr_en, wr_addr and wr_data registered in cycle N+1.
  - wr_en lasts exactly one cycle per accepted byte.
  - wr_addr and wr_data hold their last values when wr_en=0.
- frame_done asserts in the same cycle as wr_en for the last address.
- Control byte in cycle N: the state/counter effect is visible in cycle N+1.
  - swap_pending rises in N+1.
- Swap execution:
  - Swap executes in cycle M (first cycle with state SWAP_WAIT and vblank=1).
  - In M+1, rd_buf/wr_buf are toggled and swap_pending=0.
  - A pixel byte with rx_valid in M is dropped (err_drop set).
  - A pixel byte in M+1 writes address 0 of the new back buffer.
- Simultaneous events:
  - ALIGN and swap execution in the same cycle: the swap executes and the counter is 0 either way; err_drop clears.
- Back-to-back rx_valid in consecutive cycles: every byte is processed; there is no throughput limit.

## Test plan
- Reset, then 3 pixel bytes 0x1B, 0x1B, 0x3F → three wr_en pulses:
  - Addresses 0, 1, 2; wr_data 0x1B, 0x1B, 0x3F; wr_buf=1; err_drop=0.
- ALIGN after 5 pixels, then pixel 0x2A → wr_en at addr 0, wr_data 0x2A.
- SWAP with vblank=0:
  - swap_pending=1, rd_buf stays 0.
  - Pixel 0x01 → no wr_en, err_drop=1.
  - Raise vblank → next cycle rd_buf=1, wr_buf=0, swap_pending=0.
  - Pixel 0x05 → wr_en addr 0.
- SWAP with vblank already high → rd_buf toggles within 2 cycles of the rx_valid cycle.
  - A second SWAP while pending → only one toggle.
- Fill the frame (76800 pixels, RES 320×240):
  - frame_done pulses with wr_addr=76799.
  - Pixel 76801 → no wr_en, err_drop=1.
  - ALIGN → err_drop=0, next pixel to addr 0.
- Assert rst_n low mid-frame, coincident with a wr_en cycle:
  - Outputs go to reset values immediately, rd_buf=0.
  - After release, the first pixel writes addr 0.
